// File: rtl/pll_reset_ctrl.sv
// PLL power-up / relock sequencer: holds PLL reset, waits for and debounces lock,
// then releases the system reset request. Retries on lock timeout, goes sticky-fail after MAX_RETRIES.
module pll_reset_ctrl #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 65536,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic                               refclk,
    input  logic                               rst_n,
    input  logic                               pll_locked,
    input  logic                               relock_req,
    output logic                               pll_rst,
    output logic                               sys_rst_n,
    output logic                               fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
    output logic [2:0]                         state
);

    localparam int unsigned RW      = $clog2(MAX_RETRIES + 1);
    localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned CNT_MAX = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] PRST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STAB_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [RW-1:0]   retry_inc;
    logic [1:0]      sync_q;
    logic            lock_s;
    logic            pll_rst_q, pll_rst_d;
    logic            sys_rst_n_q, sys_rst_n_d;
    logic            fail_q, fail_d;

    assign lock_s    = sync_q[1];
    assign retry_inc = retry_q + RW'(1);

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            state_q     <= S_PLL_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], pll_locked};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            fail_q      <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        retry_d = retry_q;
        unique case (state_q)
            S_PLL_RST: begin
                if (cnt_q == PRST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // Lock takes priority over a coincident timeout.
                if (lock_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TO_LAST) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RETRY_LIM) ? S_FAIL : S_PLL_RST;
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (cnt_q == STAB_LAST) begin
                    state_d = S_RUN;
                    retry_d = '0;
                end
            end
            S_RUN: begin
                cnt_d = '0;
                if (!lock_s || relock_req) state_d = S_PLL_RST;
            end
            S_FAIL: begin
                cnt_d = '0;
                if (relock_req) begin
                    state_d = S_PLL_RST;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = S_PLL_RST;
                retry_d = '0;
            end
        endcase
        if (state_d != state_q) cnt_d = '0;

        pll_rst_d   = (state_d == S_PLL_RST) || (state_d == S_FAIL);
        sys_rst_n_d = (state_d == S_RUN);
        fail_d      = (state_d == S_FAIL);
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl with short timing parameters; expected cycle
// counts are hand-derived from the sequencing rules.
module tb_pll_reset_ctrl;

    localparam int unsigned PRC = 4;
    localparam int unsigned LTO = 32;
    localparam int unsigned STC = 8;
    localparam int unsigned MXR = 2;

    localparam int P_STATE = 0;
    localparam int P_PRST  = 1;
    localparam int P_SYS   = 2;
    localparam int P_RETRY = 3;
    localparam int P_FAIL  = 4;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       fail;
    logic [1:0] retry_cnt;
    logic [2:0] state;

    int checks;
    int failures;
    int n;

    pll_reset_ctrl #(
        .PLL_RST_CYCLES (PRC),
        .LOCK_TIMEOUT   (LTO),
        .STABLE_CYCLES  (STC),
        .MAX_RETRIES    (MXR)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .fail       (fail),
        .retry_cnt  (retry_cnt),
        .state      (state)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] probe(input int what);
        case (what)
            P_STATE: return 32'(state);
            P_PRST:  return 32'(pll_rst);
            P_SYS:   return 32'(sys_rst_n);
            P_RETRY: return 32'(retry_cnt);
            default: return 32'(fail);
        endcase
    endfunction

    // Counts edges until the probed output reaches val; a bound hit shows up as a wrong count.
    task automatic wait_until(input int what, input logic [31:0] val, input int maxc, output int cnt);
        cnt = 0;
        while (probe(what) !== val && cnt < maxc) begin
            tick();
            cnt++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pll_rst"}, 32'(pll_rst), 1);
        chk({tag, "_sys_rst_n"}, 32'(sys_rst_n), 0);
        chk({tag, "_fail"}, 32'(fail), 0);
        chk({tag, "_retry"}, 32'(retry_cnt), 0);
        chk({tag, "_state"}, 32'(state), 0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        relock_req = 1'b0;

        // Power-up
        repeat (3) tick();
        chk_reset_vals("por");
        #2 rst_n = 1'b1;
        wait_until(P_PRST, 0, 20, n);
        chk("pll_rst_high_cycles", n, PRC);
        chk("wait_lock_state", 32'(state), 1);
        repeat (10) tick();
        pll_locked = 1'b1;
        wait_until(P_SYS, 1, 40, n);
        chk("lock_to_sys_rst_n", n, 2 + 1 + STC);
        chk("run_state", 32'(state), 3);
        chk("run_pll_rst", 32'(pll_rst), 0);
        chk("run_retry", 32'(retry_cnt), 0);

        // relock_req in RUN, then ignored in WAIT_LOCK
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        chk("relock_sys_rst_n", 32'(sys_rst_n), 0);
        chk("relock_pll_rst", 32'(pll_rst), 1);
        chk("relock_state", 32'(state), 0);
        wait_until(P_STATE, 1, 20, n);
        chk("relock_prst_len", n, PRC);
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        chk("relock_ignored_wl", 32'(state), 2);
        chk("relock_ignored_prst", 32'(pll_rst), 0);
        wait_until(P_SYS, 1, 20, n);
        chk("relock_stable_len", n, STC);

        // Lock loss in RUN, then a one-cycle glitch during STABLE
        pll_locked = 1'b0;
        wait_until(P_SYS, 0, 10, n);
        chk("lockloss_latency", n, 3);
        chk("lockloss_pll_rst", 32'(pll_rst), 1);
        chk("lockloss_state", 32'(state), 0);
        wait_until(P_STATE, 1, 10, n);
        chk("lockloss_prst_len", n, PRC);
        pll_locked = 1'b1;
        wait_until(P_STATE, 2, 10, n);
        chk("stable_entry", n, 3);
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        wait_until(P_STATE, 1, 10, n);
        chk("glitch_back_to_wl", n, 2);
        chk("glitch_retry", 32'(retry_cnt), 0);
        wait_until(P_STATE, 2, 10, n);
        chk("glitch_restable", n, 1);
        wait_until(P_SYS, 1, 20, n);
        chk("glitch_full_window", n, STC);

        // Lock never returns -> retries -> FAIL
        pll_locked = 1'b0;
        wait_until(P_STATE, 0, 10, n);
        chk("nolock_prst_entry", n, 3);
        wait_until(P_RETRY, 1, 80, n);
        chk("attempt1_len", n, PRC + LTO);
        chk("attempt1_state", 32'(state), 0);
        chk("attempt1_pll_rst", 32'(pll_rst), 1);
        wait_until(P_STATE, 4, 80, n);
        chk("attempt2_len", n, PRC + LTO);
        chk("fail_retry", 32'(retry_cnt), 2);
        chk("fail_flag", 32'(fail), 1);
        chk("fail_pll_rst", 32'(pll_rst), 1);
        chk("fail_sys_rst_n", 32'(sys_rst_n), 0);
        repeat (5) tick();
        chk("fail_sticky", 32'(state), 4);
        chk("fail_sticky_flag", 32'(fail), 1);
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        chk("fail_clear_flag", 32'(fail), 0);
        chk("fail_clear_retry", 32'(retry_cnt), 0);
        chk("fail_clear_state", 32'(state), 0);

        // Async reset mid-PLL_RST restarts the count
        repeat (2) tick();
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("rst_mid_prst");
        #2 rst_n = 1'b1;
        wait_until(P_STATE, 1, 20, n);
        chk("rst_mid_prst_len", n, PRC);

        // Async reset in STABLE
        pll_locked = 1'b1;
        wait_until(P_STATE, 2, 10, n);
        chk("stable2_entry", n, 3);
        repeat (2) tick();
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("rst_stable");
        #2 rst_n = 1'b1;
        wait_until(P_SYS, 1, 30, n);
        chk("rst_stable_resequence", n, PRC + 1 + STC);

        // Async reset in RUN drops sys_rst_n without a clock edge
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("rst_run");
        #2 rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
